program_loader_mem: RTL and testbench

- Program memory and boot loader that sits directly upstream of the CPU core and drives its `din` byte for every `addr` the core presents.
- Accepts a program image as a byte stream over a valid/ready handshake and writes it from address 0 upward.
- Holds the core in reset while loading, then releases it so execution starts at PC = 0.
- Replaces hard-wired test programs for both simulation and board bring-up.

---
 rtl/cpu_bus_defs_pkg.sv | 16 +
 rtl/prog_ram.sv | 27 ++
 rtl/program_loader_mem.sv | 128 ++++++++++++
 tb/tb_program_loader_mem.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_defs_pkg.sv
// Shared bus definitions for the CPU core and its program loader.
// Loader state encodings, fill byte default and core opcodes.
package cpu_bus_defs;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_HOLD = 2'd2,
      LD_RUN  = 2'd3
   } ld_state_e;

   localparam logic [7:0] OP_NOP        = 8'hEA;
   localparam logic [7:0] OP_LDA_IMM    = 8'hA9;
   localparam logic [7:0] FILL_BYTE_DEF = OP_NOP;

endpackage

// File: rtl/prog_ram.sv
// Byte RAM with one synchronous write port and one async read port.
// Contents are never reset, so a reload only overwrites what it streams.
module prog_ram #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [7:0]           wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [7:0]           rdata
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [7:0] mem [DEPTH];

   // Write port: new data becomes visible to the reader from the next cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader_mem.sv
// Program memory plus boot loader feeding the core's din byte.
// Streams an image in from address 0, holds the core in reset, then runs it.
module program_loader_mem
   import cpu_bus_defs::*;
#(
   parameter int         ADDR_BITS   = 10,
   parameter int         HOLD_CYCLES = 2,
   parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        cpu_addr,
   output logic [7:0]         cpu_din,
   output logic               cpu_reset,
   input  logic               ld_start,
   input  logic               ld_valid,
   input  logic [7:0]         ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   output logic [ADDR_BITS:0] byte_count,
   output logic               load_done,
   output logic               err_overflow
);

   localparam int                 DEPTH   = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS + 1)'(1);
   localparam logic [3:0]         HOLD_C  = 4'(HOLD_CYCLES);

   ld_state_e          state_q, state_d;
   logic [ADDR_BITS:0] cnt_q, cnt_d;
   logic [3:0]         hold_q, hold_d;
   logic               err_q, err_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic               ld_ready_q, ld_ready_d;
   logic               load_done_q, load_done_d;
   logic               we;
   logic               in_range;
   logic [7:0]         rdata;

   prog_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(cnt_q[ADDR_BITS-1:0]),
      .wdata(ld_data),
      .raddr(cpu_addr[ADDR_BITS-1:0]),
      .rdata(rdata)
   );

   // Next state, counters and write strobe; the byte count doubles as wptr
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      err_d   = err_q;
      we      = 1'b0;
      case (state_q)
         LD_IDLE, LD_RUN: begin
            if (ld_start) begin
               state_d = LD_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         LD_LOAD: begin
            if (ld_valid) begin
               if (cnt_q < DEPTH_C) begin
                  we    = 1'b1;
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  err_d = 1'b1;
               end
               if (ld_last) begin
                  state_d = LD_HOLD;
                  hold_d  = HOLD_C;
               end
            end
         end
         LD_HOLD: begin
            if (hold_q <= 4'd1) begin
               state_d = LD_RUN;
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track it exactly
   always_comb begin
      cpu_reset_d = (state_d != LD_RUN);
      ld_ready_d  = (state_d == LD_LOAD);
      load_done_d = (state_d == LD_RUN);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LD_IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         err_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         ld_ready_q  <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         err_q       <= err_d;
         cpu_reset_q <= cpu_reset_d;
         ld_ready_q  <= ld_ready_d;
         load_done_q <= load_done_d;
      end
   end

   assign in_range     = ((cpu_addr >> ADDR_BITS) == 16'd0);
   assign cpu_din      = in_range ? rdata : FILL_BYTE;
   assign cpu_reset    = cpu_reset_q;
   assign ld_ready     = ld_ready_q;
   assign load_done    = load_done_q;
   assign byte_count   = cnt_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_program_loader_mem.sv
// Self-checking bench for program_loader_mem (ADDR_BITS=4 build).
// Behavioural model plus directed literal checks and random traffic.
module tb_program_loader_mem;

   localparam int AB    = 4;
   localparam int DEPTH = 16;
   localparam int HOLD  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_reset;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic [AB:0] byte_count;
   logic        load_done;
   logic        err_overflow;

   int vectors = 0;
   int miscompares = 0;
   bit addr_rand = 1'b1;

   always #5 clk = ~clk;

   program_loader_mem #(
      .ADDR_BITS  (AB),
      .HOLD_CYCLES(HOLD),
      .FILL_BYTE  (8'hEA)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .cpu_addr    (cpu_addr),
      .cpu_din     (cpu_din),
      .cpu_reset   (cpu_reset),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .byte_count  (byte_count),
      .load_done   (load_done),
      .err_overflow(err_overflow)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase, stored bytes, count and error flag
   typedef enum {M_IDLE, M_LOAD, M_HOLD, M_RUN} mphase_e;
   mphase_e    ph = M_IDLE;
   int         cnt = 0;
   bit         err = 1'b0;
   logic [7:0] m [DEPTH];
   bit         known [DEPTH];
   int         cyc = 0;
   int         release_at = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph  <= M_IDLE;
         cnt <= 0;
         err <= 1'b0;
      end else begin
         case (ph)
            M_IDLE, M_RUN: begin
               if (ld_start) begin
                  ph  <= M_LOAD;
                  cnt <= 0;
                  err <= 1'b0;
               end
            end
            M_LOAD: begin
               if (ld_valid) begin
                  if (cnt < DEPTH) begin
                     m[cnt]     <= ld_data;
                     known[cnt] <= 1'b1;
                     cnt        <= cnt + 1;
                  end else begin
                     err <= 1'b1;
                  end
                  if (ld_last) begin
                     ph         <= M_HOLD;
                     release_at <= cyc + HOLD;
                  end
               end
            end
            M_HOLD: begin
               if (cyc == release_at) ph <= M_RUN;
            end
            default: ph <= M_IDLE;
         endcase
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge clk) begin
      int a;
      check("cpu_reset", cpu_reset, 32'(ph != M_RUN));
      check("ld_ready", ld_ready, 32'(ph == M_LOAD));
      check("load_done", load_done, 32'(ph == M_RUN));
      check("byte_count", byte_count, 32'(cnt));
      check("err_overflow", err_overflow, 32'(err));
      a = int'(cpu_addr);
      if (a >= DEPTH) check("cpu_din_fill", cpu_din, 32'h00EA);
      else if (known[a]) check("cpu_din", cpu_din, 32'(m[a]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (addr_rand) cpu_addr = 16'($urandom_range(0, DEPTH + 3));
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic wait_hold(output int held);
      held = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!cpu_reset) break;
         held++;
      end
   endtask

   task automatic peek(input logic [15:0] a, input logic [7:0] exp,
                       input string name);
      addr_rand = 1'b0;
      cpu_addr  = a;
      #1;
      check(name, cpu_din, 32'(exp));
   endtask

   initial begin
      int held;
      logic [7:0] prog1 [5];
      logic [7:0] prog2 [4];
      prog1 = '{8'hA9, 8'h05, 8'h69, 8'h03, 8'hEA};
      prog2 = '{8'h11, 8'h22, 8'h33, 8'h44};
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = 8'h00;
      cpu_addr = 16'h0000;

      @(negedge clk);
      check("rst_cpu_reset", cpu_reset, 32'd1);
      check("rst_ld_ready", ld_ready, 32'd0);
      check("rst_load_done", load_done, 32'd0);
      check("rst_err", err_overflow, 32'd0);
      check("rst_count", byte_count, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_ready", ld_ready, 32'd0);

      start_load();
      check("load_ready", ld_ready, 32'd1);
      for (int i = 0; i < 5; i++) send(prog1[i], i == 4);
      check("p1_count", byte_count, 32'd5);
      check("p1_ready_off", ld_ready, 32'd0);
      wait_hold(held);
      check("p1_hold_cycles", 32'(held), 32'd2);
      check("p1_done", load_done, 32'd1);
      peek(16'h0001, 8'h05, "p1_addr1");
      peek(16'h0002, 8'h69, "p1_addr2");
      peek(16'h0400, 8'hEA, "p1_addr400");
      addr_rand = 1'b1;

      start_load();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            send(prog2[i/2], i == 6);
         end else begin
            ld_valid = 1'b0;
            ld_last  = 1'b1;
            ld_data  = 8'hFF;
            tick();
            ld_last  = 1'b0;
         end
      end
      check("p2_count", byte_count, 32'd4);
      wait_hold(held);
      for (int i = 0; i < 4; i++) peek(16'(i), prog2[i], "p2_mem");
      addr_rand = 1'b1;

      start_load();
      for (int i = 0; i < 18; i++) send(8'(8'h80 + i), i == 17);
      check("ov_count", byte_count, 32'd16);
      check("ov_err", err_overflow, 32'd1);
      wait_hold(held);
      check("ov_hold_cycles", 32'(held), 32'd2);
      peek(16'h000F, 8'h8F, "ov_addr15");
      peek(16'h0010, 8'hEA, "ov_addr16");
      peek(16'h0400, 8'hEA, "ov_addr400");
      peek(16'h0001, 8'h81, "ov_addr1");
      addr_rand = 1'b1;

      start_load();
      check("rl_cpu_reset", cpu_reset, 32'd1);
      check("rl_load_done", load_done, 32'd0);
      check("rl_err_clr", err_overflow, 32'd0);
      check("rl_count_clr", byte_count, 32'd0);
      send(8'hA2, 1'b0);
      send(8'h07, 1'b1);
      wait_hold(held);
      peek(16'h0000, 8'hA2, "rl_addr0");
      peek(16'h0001, 8'h07, "rl_addr1");
      addr_rand = 1'b1;

      start_load();
      send(8'h5A, 1'b0);
      send(8'hC3, 1'b0);
      rst_n = 1'b0;
      #2;
      check("mid_cpu_reset", cpu_reset, 32'd1);
      check("mid_count", byte_count, 32'd0);
      check("mid_ready", ld_ready, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) send(8'($urandom), i == 2);
      check("idle_count", byte_count, 32'd0);
      check("idle_ready2", ld_ready, 32'd0);
      peek(16'h0001, 8'hC3, "mid_mem_kept");
      addr_rand = 1'b1;

      for (int i = 0; i < 800; i++) begin
         rst_n    = ($urandom % 64) != 0;
         ld_start = ($urandom % 12) == 0;
         ld_valid = $urandom % 2;
         ld_data  = 8'($urandom);
         if (i < 400) ld_last = ($urandom % 8) == 0;
         else         ld_last = ($urandom % 40) == 0;
         tick();
      end
      rst_n    = 1'b1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
